// File: rtl/cmp_seq_pkg.sv
// cmp_seq_pkg: FSM state, one-hot result type and slice-count helpers for cmp_seq_ctrl
package cmp_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } res_t;
  localparam int DEF_WIDTH = 32;
  localparam int NUM_SLICES = DEF_WIDTH / 2;
  function automatic int num_slices(input int width);
    return width / 2;
  endfunction
endpackage

// File: rtl/comparator_2bit.sv
// comparator_2bit: 2-bit magnitude compare cell; ports a, b in; a_larger, b_larger, equal out
module comparator_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       a_larger,
  output logic       b_larger,
  output logic       equal
);
  assign a_larger = a > b;
  assign b_larger = b > a;
  assign equal    = a == b;
endmodule

// File: rtl/cmp_seq_ctrl.sv
// cmp_seq_ctrl: MSB-first serial WIDTH-bit compare via one 2-bit slice; req valid/ready in (a, b, signed), resp valid/ready out (gt/eq/lt), flush, busy
module cmp_seq_ctrl
  import cmp_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_signed,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_gt,
  output logic             resp_eq,
  output logic             resp_lt,
  output logic             busy
);
  localparam int NS = num_slices(WIDTH);
  localparam int IW = $clog2(NS);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam res_t RES_EQ = res_t'(3'b010);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  res_t res_q, res_d, hit;
  logic [1:0] slice_a, slice_b;
  logic a_larger, b_larger, equal, last;
  assign slice_a = a_q[{idx_q, 1'b0} +: 2];
  assign slice_b = b_q[{idx_q, 1'b0} +: 2];
  comparator_2bit u_cmp (
    .a(slice_a),
    .b(slice_b),
    .a_larger(a_larger),
    .b_larger(b_larger),
    .equal(equal)
  );
  // Flipping the sign bit turns two's-complement order into unsigned order.
  // res_q stays zero through RUN until the first unequal slice is seen, so
  // later slices cannot overwrite the decision when running constant latency.
  always_comb begin
    hit = (res_q == '0 && !equal) ? res_t'({a_larger, 1'b0, b_larger}) : res_q;
    last = (EARLY_EXIT && !equal) || idx_q == '0;
    state_d = state_q;
    idx_d = idx_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    if (flush) begin
      state_d = IDLE;
      res_d = '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          state_d = RUN;
          idx_d = IW'(NS - 1);
          a_d = req_a ^ (req_signed ? MSB : '0);
          b_d = req_b ^ (req_signed ? MSB : '0);
          res_d = '0;
        end
        RUN: begin
          res_d = (last && hit == '0) ? RES_EQ : hit;
          state_d = last ? DONE : RUN;
          idx_d = last ? idx_q : idx_q - 1'b1;
        end
        DONE: if (resp_ready) begin
          state_d = IDLE;
          res_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
    end
  end
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign resp_gt    = resp_valid & res_q.gt;
  assign resp_eq    = resp_valid & res_q.eq;
  assign resp_lt    = resp_valid & res_q.lt;
endmodule
